posit_accum_es3: RTL
====================

POSIT_ACCUM_ES3 -- requirements
Module: posit_accum_es3

Interface
REQ-001 Parameter NBITS, 32, posit width; es=3 format.
REQ-002 Parameter ADD_LATENCY, 4, adder cycles from add_start to matching add_done.
REQ-003 Parameter RQ_DEPTH, 8, result-queue entries; SHALL be >= ADD_LATENCY+1.
REQ-004 Port clk  in  1  single clock; all logic on rising edge.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port in_valid / in_ready  in/out  1/1  input posit stream handshake.
REQ-007 Port in_data  in  32  posit operand; in_last  in  1  final element of packet.
REQ-008 Port out_valid / out_ready  out/in  1/1  packet-sum handshake.
REQ-009 Port out_data  out  32  packet sum; out_inf, out_zero  out  1  sum is NaR / exact zero.
REQ-010 Port add_in1, add_in2  out  32  adder operands; add_start  out  1  issue strobe; all three registered.
REQ-011 Port add_result  in  32; add_done  in  1  adder return; add_inf, add_zero  in  1  unused.

Function
REQ-012 Block SHALL reduce each packet (in_last-terminated, >=1 element) to one posit sum using an external pipelined adder; in-packet summation order is unspecified.
REQ-013 Transfer occurs when valid & ready high at the same edge, for both streams.
REQ-014 Pending register P (32b + valid) and result queue RQ (FIFO, RQ_DEPTH) SHALL be kept; outstanding counter OC (0..ADD_LATENCY) SHALL track issued-not-returned adds.
REQ-015 Each cycle source X = RQ head if RQ non-empty, else accepted input element, else none.
REQ-016 If X present and P invalid: load X into P; set P valid.
REQ-017 If X present and P valid: next edge add_in1=P, add_in2=X, add_start=1; P cleared; otherwise add_start=0 next edge.
REQ-018 in_ready SHALL be 1 only in ACCUM with RQ empty and OC+RQ count < RQ_DEPTH.
REQ-019 add_done=1 SHALL push add_result into RQ same edge; simultaneous push and pop allowed.
REQ-020 OC +1 on add_start, -1 on add_done, unchanged if both.
REQ-021 States ACCUM, DRAIN, OUTPUT; reset state ACCUM.
REQ-022 ACCUM -> DRAIN on edge accepting in_last=1.
REQ-023 DRAIN -> OUTPUT when OC=0, RQ empty, no add_start pending, P valid; out_data<=P, out_valid<=1.
REQ-024 OUTPUT: out_data, out_inf, out_zero stable while out_valid=1 and out_ready=0; in_ready=0.
REQ-025 OUTPUT -> ACCUM on out_ready=1: out_valid<=0, P cleared.
REQ-026 out_inf = (out_data==32'h80000000); out_zero = (out_data==0).
REQ-027 Single-element packet SHALL produce output with zero add_start pulses; an N-element packet SHALL issue exactly N-1 adds.
REQ-028 RQ overflow SHALL never occur; assertion required.

Reset
REQ-029 On reset: out_valid, add_start, in_ready = 0; out_data, add_in1, add_in2 = 0; out_inf, out_zero = 0; P, RQ, OC cleared; state ACCUM.
REQ-030 Adder has no reset: flush counter SHALL load ADD_LATENCY during reset and decrement afterward; add_done ignored while nonzero; in_ready held 0 until zero.
REQ-031 Reset mid-packet SHALL discard all partial sums; next packet starts clean.

Verification
REQ-032 Packet {0x40000000,last} -> out_data=0x40000000, out_zero=0, no add_start.
REQ-033 Packet {0x40000000, 0x40000000 last} -> one add_start, in1=in2=0x40000000; out_data=0x44000000.
REQ-034 Eight x 0x40000000, in_valid continuous -> exactly 7 add_start pulses, out_data=0x4C000000, OC never > 4.
REQ-035 {0x40000000, 0xC0000000 last} -> out_data=0x00000000, out_zero=1, out_inf=0.
REQ-036 Sum ready, out_ready low 10 cycles -> out_valid=1 and out_data stable 10 cycles, in_ready=0; transfer on cycle 11.
REQ-037 Reset asserted after 3 of 5 elements, stale add_done injected 2 cycles later -> ignored; next packet {0x44000000 last} -> out_data=0x44000000.

Source files
------------

// File: rtl/posit_accum_es3.sv
// posit_accum_es3: reduces in_last-terminated posit (es=3) packets to one sum via an external pipelined adder
//   in_*   : operand stream (valid/ready), in_last marks the final element of a packet
//   out_*  : packet sum (valid/ready), out_inf = NaR, out_zero = exact zero
//   add_*  : registered operands/strobe to the adder, result/done back from it
module posit_accum_es3 #(
  parameter int NBITS       = 32,
  parameter int ADD_LATENCY = 4,
  parameter int RQ_DEPTH    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] out_data,
  output logic             out_inf,
  output logic             out_zero,
  output logic [NBITS-1:0] add_in1,
  output logic [NBITS-1:0] add_in2,
  output logic             add_start,
  input  logic [NBITS-1:0] add_result,
  input  logic             add_done,
  input  logic             add_inf,
  input  logic             add_zero
);
  localparam int AW = $clog2(RQ_DEPTH);
  localparam int CW = $clog2(RQ_DEPTH + 1);
  localparam int OW = $clog2(ADD_LATENCY + 1) + 1;
  localparam int FW = $clog2(ADD_LATENCY + 1);
  localparam logic [NBITS-1:0] NAR = {1'b1, {(NBITS-1){1'b0}}};
  typedef enum logic [1:0] {ACCUM, DRAIN, OUTPUT} state_t;
  state_t           state_q, state_d;
  logic [NBITS-1:0] p_q, p_d;
  logic             pv_q, pv_d;
  logic [NBITS-1:0] rq_q [RQ_DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [OW-1:0]    oc_q, oc_d;
  logic [FW-1:0]    fl_q, fl_d;
  logic             out_valid_q, out_valid_d, out_inf_q, out_inf_d, out_zero_q, out_zero_d;
  logic [NBITS-1:0] out_data_q, out_data_d, add_in1_q, add_in1_d, add_in2_q, add_in2_d;
  logic             add_start_q, add_start_d;
  logic             flushed, push, pop, rq_empty, in_fire, x_v, issue, go_out, take;
  logic [NBITS-1:0] x;
  logic             unused_ok;
  assign unused_ok = ^{add_inf, add_zero};
  // adder results still in flight from before reset are dropped until the flush counter expires
  assign flushed  = fl_q == '0;
  assign push     = add_done && flushed;
  assign rq_empty = cnt_q == '0;
  assign pop      = !rq_empty;
  assign in_ready = state_q == ACCUM && rq_empty && flushed && (int'(oc_q) + int'(cnt_q) < RQ_DEPTH);
  assign in_fire  = in_valid && in_ready;
  // partial sums take priority over fresh input as the next operand
  assign x_v      = pop || in_fire;
  assign x        = pop ? rq_q[rd_q] : in_data;
  assign issue    = x_v && pv_q;
  always_comb begin
    go_out      = state_q == DRAIN && oc_q == '0 && rq_empty && !add_start_q && pv_q;
    take        = state_q == OUTPUT && out_ready;
    state_d     = (state_q == ACCUM && in_fire && in_last) ? DRAIN : go_out ? OUTPUT : take ? ACCUM : state_q;
    p_d         = (x_v && !pv_q) ? x : p_q;
    pv_d        = take ? 1'b0 : x_v ? !pv_q : pv_q;
    rd_d        = pop ? ((rd_q == AW'(RQ_DEPTH - 1)) ? '0 : rd_q + 1'b1) : rd_q;
    wr_d        = push ? ((wr_q == AW'(RQ_DEPTH - 1)) ? '0 : wr_q + 1'b1) : wr_q;
    cnt_d       = cnt_q + CW'(push) - CW'(pop);
    oc_d        = oc_q + OW'(issue) - OW'(push);
    fl_d        = flushed ? fl_q : fl_q - 1'b1;
    add_start_d = issue;
    add_in1_d   = issue ? p_q : add_in1_q;
    add_in2_d   = issue ? x : add_in2_q;
    out_valid_d = go_out ? 1'b1 : take ? 1'b0 : out_valid_q;
    out_data_d  = go_out ? p_q : out_data_q;
    out_inf_d   = go_out ? p_q == NAR : out_inf_q;
    out_zero_d  = go_out ? p_q == '0 : out_zero_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ACCUM;
      p_q         <= '0;
      pv_q        <= 1'b0;
      rd_q        <= '0;
      wr_q        <= '0;
      cnt_q       <= '0;
      oc_q        <= '0;
      fl_q        <= FW'(ADD_LATENCY);
      add_start_q <= 1'b0;
      add_in1_q   <= '0;
      add_in2_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_inf_q   <= 1'b0;
      out_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      pv_q        <= pv_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
      oc_q        <= oc_d;
      fl_q        <= fl_d;
      add_start_q <= add_start_d;
      add_in1_q   <= add_in1_d;
      add_in2_q   <= add_in2_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_inf_q   <= out_inf_d;
      out_zero_q  <= out_zero_d;
    end
    if (push) rq_q[wr_q] <= add_result;
  end
  always_ff @(posedge clk)
    if (!reset) assert (!(push && !pop && cnt_q == CW'(RQ_DEPTH)));
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_inf   = out_inf_q;
  assign out_zero  = out_zero_q;
  assign add_start = add_start_q;
  assign add_in1   = add_in1_q;
  assign add_in2   = add_in2_q;
endmodule
